// File: rtl/systolic_result_collector.sv
// systolic_result_collector: de-skews the bottom-edge column outputs of an NxN systolic array
// into a row-major buffer and drains it as a valid/ready word stream.
module systolic_result_collector #(
    parameter int DATA_W = 16,
    parameter int N      = 4,
    parameter int LAT    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    clear,
    input  logic                    shift_en,
    input  logic [N*DATA_W-1:0]     ps_bottom_in_flat,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [$clog2(N*N)-1:0]  out_idx,
    output logic                    done
);
    localparam int IW = $clog2(N*N);
    localparam int CW = $clog2(LAT + 2*N);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    state_t            state_q;
    logic [CW-1:0]     shift_cnt_q;
    logic [IW-1:0]     idx_q;
    logic [IW-1:0]     idx_d;
    logic [DATA_W-1:0] buf_q [N*N];
    logic [DATA_W-1:0] buf_d [N*N];
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic              done_q;
    logic              last_shift;

    // Column j's row k leaves the array on shift LAT+k+j, hence the diagonal de-skew.
    always_comb begin
        buf_d = buf_q;
        for (int k = 0; k < N; k++)
            for (int j = 0; j < N; j++)
                if (state_q == CAPTURE && shift_en && shift_cnt_q == CW'(LAT + k + j))
                    buf_d[k*N + j] = ps_bottom_in_flat[j*DATA_W +: DATA_W];
    end

    assign last_shift = shift_cnt_q == CW'(LAT + 2*N - 2);
    assign idx_d      = idx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q     <= IDLE;
            shift_cnt_q <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            for (int i = 0; i < N*N; i++) buf_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            buf_q  <= buf_d;
            case (state_q)
                IDLE: if (start) begin
                    state_q     <= CAPTURE;
                    shift_cnt_q <= '0;
                end
                CAPTURE: if (shift_en) begin
                    shift_cnt_q <= shift_cnt_q + 1'b1;
                    if (last_shift) begin
                        state_q     <= DRAIN;
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= buf_d[0];
                    end
                end
                DRAIN: if (out_ready) begin
                    if (idx_q == IW'(N*N - 1)) begin
                        state_q     <= IDLE;
                        idx_q       <= '0;
                        out_valid_q <= 1'b0;
                        out_data_q  <= '0;
                        done_q      <= 1'b1;
                    end else begin
                        idx_q      <= idx_d;
                        out_data_q <= buf_q[idx_d];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = state_q != IDLE;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = idx_q;
    assign done      = done_q;
endmodule

// File: tb/tb_systolic_result_collector.sv
// tb_systolic_result_collector: scoreboard bench; instance 0 uses LAT=0, instance 1 uses LAT=2.
module tb_systolic_result_collector;
    localparam int N = 4;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] start, clear, shift_en, out_ready, busy, out_valid, done;
    logic [N*W-1:0] ps [2];
    logic [W-1:0] out_data [2];
    logic [3:0] out_idx [2];

    typedef struct {
        int s;
        int idx;
        logic [W-1:0] d;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad = 0;
    logic [1:0] exp_done = '0;
    logic [1:0] hold_v = '0;
    logic [W-1:0] hold_d [2];
    logic [3:0] hold_i [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        systolic_result_collector #(.DATA_W(W), .N(N), .LAT(2*g)) dut (
            .clk(clk), .rst(rst), .start(start[g]), .clear(clear[g]), .shift_en(shift_en[g]),
            .ps_bottom_in_flat(ps[g]), .busy(busy[g]), .out_valid(out_valid[g]),
            .out_ready(out_ready[g]), .out_data(out_data[g]), .out_idx(out_idx[g]), .done(done[g])
        );
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (rst) begin
                exp_done[s] <= 1'b0;
                hold_v[s]   <= 1'b0;
            end else begin
                if (done[s] || exp_done[s]) begin
                    check("done_pulse", int'(done[s]), int'(exp_done[s]));
                    check("busy_at_done", int'(busy[s]), 0);
                end
                if (!out_valid[s]) check("data_zero_when_invalid", int'(out_data[s]), 0);
                if (hold_v[s] && out_valid[s]) begin
                    check("stall_data", int'(out_data[s]), int'(hold_d[s]));
                    check("stall_idx", int'(out_idx[s]), int'(hold_i[s]));
                end
                if (out_valid[s] && out_ready[s]) begin
                    check("word_expected", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        check("word_dut", s, e.s);
                        check("word_idx", int'(out_idx[s]), e.idx);
                        check("word_data", int'(out_data[s]), int'(e.d));
                        exp_done[s] <= (e.idx == N*N - 1);
                    end else exp_done[s] <= 1'b0;
                end else exp_done[s] <= 1'b0;
                hold_v[s] <= out_valid[s] && !out_ready[s];
                hold_d[s] <= out_data[s];
                hold_i[s] <= out_idx[s];
            end
        end
    end

    task automatic check_reset(input int s);
        check("rst_busy", int'(busy[s]), 0);
        check("rst_valid", int'(out_valid[s]), 0);
        check("rst_data", int'(out_data[s]), 0);
        check("rst_idx", int'(out_idx[s]), 0);
        check("rst_done", int'(done[s]), 0);
    endtask

    // Result[r][c] is whatever column c carried on shift r+c+lat.
    task automatic run_capture(input int s, input int lat, input bit rnd, input bit gap,
                               input bit shift_with_start, input int abort_at);
        logic [W-1:0] sh [12][N];
        int ns = lat + 2*N - 1;
        int t = 0;
        bit ph = 1'b0;
        for (int i = 0; i < ns; i++)
            for (int j = 0; j < N; j++)
                sh[i][j] = rnd ? W'($urandom) : W'(16*i + j);
        if (abort_at < 0)
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    exp_t e;
                    e.s = s;
                    e.idx = r*N + c;
                    e.d = sh[r + c + lat][c];
                    sb.push_back(e);
                end
        @(posedge clk); #1;
        start[s] = 1'b1;
        shift_en[s] = shift_with_start;
        ps[s] = '1;
        @(posedge clk); #1;
        start[s] = 1'b0;
        while (t < ns) begin
            if (gap && ph) shift_en[s] = 1'b0;
            else begin
                shift_en[s] = 1'b1;
                for (int j = 0; j < N; j++) ps[s][j*W +: W] = sh[t][j];
                clear[s] = (t == abort_at);
                t++;
            end
            ph = ~ph;
            @(posedge clk); #1;
            if (clear[s]) begin
                clear[s] = 1'b0;
                shift_en[s] = 1'b0;
                check("clear_busy", int'(busy[s]), 0);
                check("clear_valid", int'(out_valid[s]), 0);
                return;
            end
        end
        shift_en[s] = 1'b0;
    endtask

    task automatic drain(input int s, input int stall_idx, input int stall_len, input int rst_at);
        int st = 0;
        int n = 0;
        out_ready[s] = 1'b1;
        while ((busy[s] || out_valid[s]) && n < 200) begin
            if (out_valid[s] && int'(out_idx[s]) == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                sb.delete();
                out_ready[s] = 1'b0;
                check_reset(s);
                return;
            end
            @(posedge clk); #1;
            n++;
            if (out_valid[s] && int'(out_idx[s]) == stall_idx && st < stall_len) begin
                out_ready[s] = 1'b0;
                st++;
            end else out_ready[s] = 1'b1;
        end
        out_ready[s] = 1'b0;
        check("drain_finished", int'(busy[s]), 0);
        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        start = '0;
        clear = '0;
        shift_en = '0;
        out_ready = '0;
        ps[0] = '0;
        ps[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset(0);
        check_reset(1);
        // basic run
        run_capture(0, 0, 1'b0, 1'b0, 1'b0, -1);
        drain(0, -1, 0, -1);
        // gapped shifts, stall at idx 7
        run_capture(0, 0, 1'b0, 1'b1, 1'b0, -1);
        drain(0, 7, 3, -1);
        // LAT=2 instance
        run_capture(1, 2, 1'b0, 1'b0, 1'b0, -1);
        drain(1, -1, 0, -1);
        // abort by clear, then fresh run
        run_capture(0, 0, 1'b1, 1'b0, 1'b0, 3);
        repeat (3) @(posedge clk);
        #1;
        run_capture(0, 0, 1'b1, 1'b0, 1'b0, -1);
        drain(0, -1, 0, -1);
        // start with shift in IDLE, start again during DRAIN
        run_capture(0, 0, 1'b0, 1'b0, 1'b1, -1);
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        check("drain_start_valid", int'(out_valid[0]), 1);
        check("drain_start_idx", int'(out_idx[0]), 0);
        drain(0, -1, 0, -1);
        // reset mid-drain, then a clean run
        run_capture(0, 0, 1'b0, 1'b0, 1'b0, -1);
        drain(0, -1, 0, 9);
        run_capture(0, 0, 1'b0, 1'b0, 1'b0, -1);
        drain(0, -1, 0, -1);
        // random data on both instances
        for (int i = 0; i < 6; i++) begin
            int s = i % 2;
            run_capture(s, 2*s, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
            drain(s, int'($urandom_range(0, 15)), int'($urandom_range(1, 4)), -1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
